// File: rtl/hazard_pkg.sv
// Shared types for the ID/EX hazard controller: FSM states, scoreboard entry
// layout and the per-source hazard classification rule.
package hazard_pkg;

  localparam int unsigned REG_W_DEF = 3;
  // Scoreboard stores destination specifiers at a fixed width; REG_W <= SB_RD_W.
  localparam int unsigned SB_RD_W   = 8;

  typedef enum logic [2:0] {
    RUN,
    DEP_STALL,
    MEM_WAIT,
    DRAIN,
    HALTED
  } hz_state_t;

  typedef struct packed {
    logic               valid;
    logic [SB_RD_W-1:0] rd;
    logic               is_load;
    logic               is_halt;
  } sb_entry_t;

  // Returns {stall, forward}; the EX entry is the newer producer and wins.
  function automatic logic [1:0] classify_src(
    input logic               used,
    input logic [SB_RD_W-1:0] src,
    input sb_entry_t          ex_e,
    input sb_entry_t          mem_e
  );
    logic ex_hit;
    logic mem_hit;
    ex_hit  = used && ex_e.valid && (ex_e.rd == src);
    mem_hit = used && mem_e.valid && (mem_e.rd == src);
    if (ex_hit)  return ex_e.is_load ? 2'b01 : 2'b10;
    if (mem_hit) return 2'b10;
    return 2'b00;
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Two-entry destination scoreboard (EX, MEM) plus RAW match/classify logic
// for the instruction currently in ID.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             bubble,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_writes,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             id_halt,
  output logic             stall_req,
  output logic             warn_a_nxt,
  output logic             warn_b_nxt,
  output logic             pipe_empty
);

  sb_entry_t  ex_q;
  sb_entry_t  mem_q;
  sb_entry_t  ex_nxt;
  logic [1:0] cls_a;
  logic [1:0] cls_b;

  always_comb begin
    ex_nxt         = '0;
    ex_nxt.valid   = id_valid & id_writes & ~bubble;
    ex_nxt.rd      = SB_RD_W'(id_rd);
    ex_nxt.is_load = id_is_load;
    ex_nxt.is_halt = id_valid & id_halt & ~bubble;

    cls_a = classify_src(id_uses_rs, SB_RD_W'(id_rs), ex_q, mem_q);
    cls_b = classify_src(id_uses_rt, SB_RD_W'(id_rt), ex_q, mem_q);

    stall_req  = id_valid & (cls_a[1] | cls_b[1]);
    warn_a_nxt = id_valid & cls_a[0];
    warn_b_nxt = id_valid & cls_b[0];
    pipe_empty = ~(ex_q.valid | ex_q.is_halt | mem_q.valid | mem_q.is_halt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
    end else if (advance) begin
      mem_q <= ex_q;
      ex_q  <= ex_nxt;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard/sequencing controller at the ID/EX boundary: RAW stalls,
// branch flush, data-memory freeze, halt drain and load-forward selects.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             id_writes,
  input  logic [REG_W-1:0] id_rd,
  input  logic             id_is_load,
  input  logic             id_halt,
  input  logic             ex_pcsrc,
  input  logic             mem_stall,
  output logic             pc_hold,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             pipe_freeze,
  output logic             load_warning_a,
  output logic             load_warning_b,
  output logic             halted
);

  hz_state_t state_q;
  hz_state_t ret_q;
  hz_state_t eff_state;
  logic      stall_req;
  logic      warn_a_nxt;
  logic      warn_b_nxt;
  logic      pipe_empty;
  logic      advance;
  logic      go;
  logic      is_halted;
  logic      dep_stall;
  logic      drain_hold;
  logic      halt_enter;

  hazard_scoreboard #(.REG_W(REG_W)) u_sb (
    .clk        (clk),
    .rst_n      (rst_n),
    .advance    (advance),
    .bubble     (idex_bubble),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rs (id_uses_rs),
    .id_uses_rt (id_uses_rt),
    .id_writes  (id_writes),
    .id_rd      (id_rd),
    .id_is_load (id_is_load),
    .id_halt    (id_halt),
    .stall_req  (stall_req),
    .warn_a_nxt (warn_a_nxt),
    .warn_b_nxt (warn_b_nxt),
    .pipe_empty (pipe_empty)
  );

  // While frozen the FSM parks in MEM_WAIT; the remembered state drives
  // decisions on the first cycle after the freeze lifts.
  always_comb begin
    eff_state   = (state_q == MEM_WAIT) ? ret_q : state_q;
    is_halted   = (state_q == HALTED);
    go          = ~mem_stall & ~ex_pcsrc;
    pipe_freeze = mem_stall;
    ifid_flush  = ~mem_stall & ex_pcsrc & ~is_halted;
    dep_stall   = go & stall_req & ((eff_state == RUN) || (eff_state == DEP_STALL));
    drain_hold  = go & (eff_state == DRAIN);
    pc_hold     = dep_stall | drain_hold | is_halted;
    idex_bubble = ifid_flush | dep_stall | drain_hold;
    advance     = ~mem_stall & ~is_halted;
    halt_enter  = advance & ~idex_bubble & id_valid & id_halt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RUN;
      ret_q          <= RUN;
      load_warning_a <= 1'b0;
      load_warning_b <= 1'b0;
      halted         <= 1'b0;
    end else begin
      if (advance) begin
        load_warning_a <= warn_a_nxt & ~idex_bubble;
        load_warning_b <= warn_b_nxt & ~idex_bubble;
      end
      if (!is_halted) begin
        if (mem_stall) begin
          if (state_q != MEM_WAIT) ret_q <= state_q;
          state_q <= MEM_WAIT;
        end else if (eff_state == DRAIN) begin
          if (ex_pcsrc) begin
            state_q <= RUN;
          end else if (pipe_empty) begin
            state_q <= HALTED;
            halted  <= 1'b1;
          end else begin
            state_q <= DRAIN;
          end
        end else if (ex_pcsrc) begin
          state_q <= RUN;
        end else if (stall_req) begin
          state_q <= DEP_STALL;
        end else if (halt_enter) begin
          state_q <= DRAIN;
        end else begin
          state_q <= RUN;
        end
      end
    end
  end

endmodule
